burst_line_adaptor: RTL and testbench
=====================================

# burst_line_adaptor

Parametrised bridge between a last-level cache that moves whole lines and a memory port that moves fixed-width beats. Generalises line and beat width (any integer beat count ≥2), registers the request address and write data at acceptance, and reports completion with a one-cycle pulse. A compile-time watchdog can abort a stalled transfer and flag an error. Sits between the LLC miss/writeback path and the memory burst interface.

## Interface
- `s_line`, 256, cache line width in bits.
- `s_burst`, 64, memory beat width in bits; `s_line` must be an integer multiple of `s_burst`, with `n_burst = s_line/s_burst` ≥ 2.
- `timeout_cycles`, 1024, idle cycles without `resp_i` before abort (used only when the watchdog is compiled in).
- `clk` in 1: clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `line_i` in `s_line`: write line from the LLC.
- `line_o` out `s_line`: read line to the LLC.
- `address_i` in 32: line address from the LLC.
- `read_i` in 1: LLC read request, held until `resp_o`.
- `write_i` in 1: LLC write request, held until `resp_o`.
- `resp_o` out 1: one-cycle completion pulse.
- `err_o` out 1: abort flag, valid with `resp_o`.
- `burst_i` in `s_burst`: read beat from memory.
- `burst_o` out `s_burst`: write beat to memory.
- `address_o` out 32: registered, line-aligned address to memory.
- `read_o` out 1: memory read request.
- `write_o` out 1: memory write request.
- `resp_i` in 1: memory beat strobe; one beat transferred per high cycle.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: if `read_i`, go to READ; else if `write_i`, go to WRITE. Read wins if both are high. On acceptance, latch `address_i` with the low `$clog2(s_line/8)` bits forced to 0. For a write, also latch `line_i` into the line buffer. Clear the beat counter.
- READ: `read_o` = 1. On each `resp_i`, store `burst_i` into `buffer[cnt*s_burst +: s_burst]` and increment `cnt`. The beat with `cnt == n_burst-1` moves the FSM to DONE.
- WRITE: `write_o` = 1 and `burst_o = buffer[cnt*s_burst +: s_burst]`. On each `resp_i`, increment `cnt`. The last beat moves the FSM to DONE.
- DONE: `resp_o` = 1 and `read_o`/`write_o` = 0 for exactly one cycle, then go to IDLE. `line_o` drives the buffer and stays stable until the next write acceptance or read beat.
- `burst_o` is 0 outside WRITE. `resp_i` is ignored in IDLE and DONE.
- `address_o` holds its value from acceptance until the next acceptance.
- The LLC drops its request in the cycle after `resp_o`. The adaptor therefore never re-accepts the same request.
- Changes to `read_i`, `write_i`, `address_i` or `line_i` mid-transfer have no effect.
- Reset, at any time including mid-transfer: go to IDLE; clear counter, buffer, `address_o`, and all timers. All outputs are 0 at reset. The abandoned memory transaction is not completed.

## Timing
- Request seen in IDLE at cycle 0 → `read_o`/`write_o` high from cycle 1.
- Zero-wait memory (`resp_i` high cycles 1..n_burst) → `resp_o` in cycle n_burst+1. This is the minimum latency.
- Each low `resp_i` cycle adds one cycle of latency.
- Back-to-back requests: the earliest next acceptance is the IDLE cycle n_burst+2.
- `read_o`/`write_o` fall in the DONE cycle, one cycle after the last beat.

## Configuration
- Macro: `BURST_LINE_ADAPTOR_TIMEOUT_EN`.
- Defined:
  - A cycle counter runs in READ/WRITE and resets on every `resp_i`.
  - When it reaches `timeout_cycles`, the FSM goes to DONE with `resp_o` = 1 and `err_o` = 1 in that DONE cycle.
  - `line_o` contents are undefined on an aborted read.
  - `err_o` is 0 in all other cycles.
- Undefined: no timer flops are built, the FSM waits indefinitely, and `err_o` is tied to 0.

## Test plan
- Read, defaults, zero-wait: `read_i`=1 with `address_i`=0x0000_1234. Beats 0x11..11, 0x22..22, 0x33..33, 0x44..44. Expect `address_o`=0x0000_1220, `resp_o` at cycle 5, and `line_o`={0x44..44,0x33..33,0x22..22,0x11..11}.
- Write with wait states: `line_i`={D3,D2,D1,D0} and `resp_i` high only on alternate cycles. Expect `burst_o` to show D0,D1,D2,D3 in order on the strobed cycles. Expect `line_i` changes after acceptance to be ignored and `resp_o` at cycle 8.
- Simultaneous `read_i`+`write_i`: expect only `read_o` to assert. Then the held write is serviced after `resp_o`.
- Reset asserted mid-READ after 2 beats: expect all outputs 0 immediately. A new read after release must complete with a counter starting from 0.
- `s_line`=512, `s_burst`=128: expect 4 beats placed at the correct offsets and `resp_o` at cycle 5.
- With `BURST_LINE_ADAPTOR_TIMEOUT_EN` and `timeout_cycles`=8: one beat, then `resp_i` held 0. Expect `resp_o`=`err_o`=1 for one cycle, 9 cycles after that beat, then IDLE. Without the macro, expect no response.

Source files
------------

// File: rtl/burst_line_adaptor.sv
// Line-to-beat bridge between the LLC and a fixed-width memory burst port.
// Optional stall watchdog: define BURST_LINE_ADAPTOR_TIMEOUT_EN.
module burst_line_adaptor #(
  parameter int s_line         = 256,
  parameter int s_burst        = 64,
  parameter int timeout_cycles = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [s_line-1:0] line_i,
  output logic [s_line-1:0] line_o,
  input  logic [31:0]       address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  output logic              err_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]       address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
);

  localparam int n_burst = s_line / s_burst;
  localparam int cnt_w   = $clog2(n_burst);
  localparam int off_w   = $clog2(s_line / 8);
  localparam logic [31:0] addr_mask =
    ~((32'd1 << off_w) - 32'd1);

  if (s_line % s_burst != 0 || n_burst < 2) begin : g_bad_geom
    $error("s_line must be a multiple (>=2) of s_burst");
  end
  if (timeout_cycles < 1) begin : g_bad_tmo
    $error("timeout_cycles must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [cnt_w-1:0]  cnt_q;
  logic [s_line-1:0] buf_q;
  logic [31:0]       addr_q;
  logic              last_beat;
  logic              abort;

  assign last_beat = resp_i && (cnt_q == cnt_w'(n_burst - 1));
  assign line_o    = buf_q;
  assign address_o = addr_q;

`ifdef BURST_LINE_ADAPTOR_TIMEOUT_EN
  localparam int tmr_w = $clog2(timeout_cycles + 1);

  logic [tmr_w-1:0] tmr_q;
  logic             err_q;
  logic             busy;

  assign busy  = (state_q == READ) || (state_q == WRITE);
  assign abort = busy && !resp_i &&
                 (tmr_q == tmr_w'(timeout_cycles - 1));
  assign err_o = err_q && (state_q == DONE);

  // Idle-cycle timer restarts on every beat strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (!busy || resp_i) begin
        tmr_q <= '0;
      end else begin
        tmr_q <= tmr_q + tmr_w'(1);
      end
      if (abort) begin
        err_q <= 1'b1;
      end else if (state_q == IDLE) begin
        err_q <= 1'b0;
      end
    end
  end
`else
  assign abort = 1'b0;
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    read_o  = 1'b0;
    write_o = 1'b0;
    resp_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (read_i) begin
          state_d = READ;
        end else if (write_i) begin
          state_d = WRITE;
        end
      end
      READ: begin
        read_o = 1'b1;
        if (last_beat || abort) begin
          state_d = DONE;
        end
      end
      WRITE: begin
        write_o = 1'b1;
        if (last_beat || abort) begin
          state_d = DONE;
        end
      end
      DONE: begin
        resp_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      buf_q  <= '0;
      addr_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (read_i || write_i) begin
            addr_q <= address_i & addr_mask;
            cnt_q  <= '0;
            if (!read_i) begin
              buf_q <= line_i;
            end
          end
        end
        READ: begin
          if (resp_i) begin
            for (int i = 0; i < n_burst; i++) begin
              if (cnt_q == cnt_w'(i)) begin
                buf_q[i*s_burst +: s_burst] <= burst_i;
              end
            end
            cnt_q <= cnt_q + cnt_w'(1);
          end
        end
        WRITE: begin
          if (resp_i) begin
            cnt_q <= cnt_q + cnt_w'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Beat mux is only live while writing so the bus idles at zero.
  always_comb begin
    burst_o = '0;
    if (state_q == WRITE) begin
      for (int i = 0; i < n_burst; i++) begin
        if (cnt_q == cnt_w'(i)) begin
          burst_o = buf_q[i*s_burst +: s_burst];
        end
      end
    end
  end

endmodule

// File: tb/tb_burst_line_adaptor.sv
// Directed bench for burst_line_adaptor: default and 512/128 geometries.
module tb_burst_line_adaptor;

  logic         clk;
  logic         reset_n;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o, err_o;
  logic [63:0]  burst_i, burst_o;
  logic         read_o, write_o, resp_i;

  logic [511:0] w_line_i, w_line_o;
  logic [31:0]  w_address_i, w_address_o;
  logic         w_read_i, w_write_i, w_resp_o, w_err_o;
  logic [127:0] w_burst_i, w_burst_o;
  logic         w_read_o, w_write_o, w_resp_i;

  int vec;
  int errs;

  burst_line_adaptor #(
    .s_line(256), .s_burst(64), .timeout_cycles(8)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i),
    .write_i(write_i), .resp_o(resp_o), .err_o(err_o),
    .burst_i(burst_i), .burst_o(burst_o),
    .address_o(address_o), .read_o(read_o),
    .write_o(write_o), .resp_i(resp_i)
  );

  burst_line_adaptor #(
    .s_line(512), .s_burst(128), .timeout_cycles(1024)
  ) dut_w (
    .clk(clk), .reset_n(reset_n),
    .line_i(w_line_i), .line_o(w_line_o),
    .address_i(w_address_i), .read_i(w_read_i),
    .write_i(w_write_i), .resp_o(w_resp_o), .err_o(w_err_o),
    .burst_i(w_burst_i), .burst_o(w_burst_o),
    .address_o(w_address_o), .read_o(w_read_o),
    .write_o(w_write_o), .resp_i(w_resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    line_i = '0; address_i = '0; read_i = 0; write_i = 0;
    burst_i = '0; resp_i = 0;
    w_line_i = '0; w_address_i = '0; w_read_i = 0;
    w_write_i = 0; w_burst_i = '0; w_resp_i = 0;
    #12;
    vec++;
    if ({read_o, write_o, resp_o, err_o} !== 4'b0) begin
      errs++;
      $display("FAIL reset_ctl: got %b want 0000",
               {read_o, write_o, resp_o, err_o});
    end
    vec++;
    if (address_o !== 32'd0 || line_o !== '0 || burst_o !== '0) begin
      errs++;
      $display("FAIL reset_data: addr %h line %h burst %h want 0",
               address_o, line_o, burst_o);
    end
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_read();
    logic [63:0] beats [4];
    logic [255:0] exp;
    beats[0] = {16{4'h1}}; beats[1] = {16{4'h2}};
    beats[2] = {16{4'h3}}; beats[3] = {16{4'h4}};
    exp = {beats[3], beats[2], beats[1], beats[0]};
    address_i = 32'h0000_1234;
    read_i = 1;
    step();
    vec++;
    if (read_o !== 1'b1 || write_o !== 1'b0) begin
      errs++;
      $display("FAIL rd_req_c1: rd %b wr %b want 1 0", read_o, write_o);
    end
    vec++;
    if (address_o !== 32'h0000_1220) begin
      errs++;
      $display("FAIL rd_addr: got %h want 00001220", address_o);
    end
    for (int k = 0; k < 4; k++) begin
      resp_i = 1; burst_i = beats[k];
      if (k == 3) begin
        vec++;
        if (resp_o !== 1'b0) begin
          errs++;
          $display("FAIL rd_early_resp: got %b want 0", resp_o);
        end
      end
      step();
    end
    resp_i = 0; burst_i = '0;
    vec++;
    if (resp_o !== 1'b1 || err_o !== 1'b0 || read_o !== 1'b0) begin
      errs++;
      $display("FAIL rd_done_c5: resp %b err %b rd %b want 1 0 0",
               resp_o, err_o, read_o);
    end
    vec++;
    if (line_o !== exp) begin
      errs++;
      $display("FAIL rd_line: got %h want %h", line_o, exp);
    end
    read_i = 0;
    step();
    vec++;
    if (resp_o !== 1'b0 || read_o !== 1'b0) begin
      errs++;
      $display("FAIL rd_idle: resp %b rd %b want 0 0", resp_o, read_o);
    end
  endtask

  task automatic test_write_wait();
    logic [63:0] d [4];
    logic [255:0] orig;
    d[0] = 64'hD0D0_0000_0000_00D0; d[1] = 64'hD1D1_1111_1111_11D1;
    d[2] = 64'hD2D2_2222_2222_22D2; d[3] = 64'hD3D3_3333_3333_33D3;
    orig = {d[3], d[2], d[1], d[0]};
    line_i = orig;
    address_i = 32'h0000_2000;
    write_i = 1;
    step();
    line_i = {4{64'hBAD0_BAD0_BAD0_BAD0}};
    for (int c = 1; c < 8; c++) begin
      vec++;
      if (write_o !== 1'b1 || resp_o !== 1'b0) begin
        errs++;
        $display("FAIL wr_busy c%0d: wr %b resp %b want 1 0",
                 c, write_o, resp_o);
      end
      resp_i = c[0];
      if (c[0]) begin
        vec++;
        if (burst_o !== d[c/2]) begin
          errs++;
          $display("FAIL wr_beat%0d: got %h want %h",
                   c / 2, burst_o, d[c/2]);
        end
      end
      step();
    end
    resp_i = 0;
    vec++;
    if (resp_o !== 1'b1 || write_o !== 1'b0 || burst_o !== '0) begin
      errs++;
      $display("FAIL wr_done_c8: resp %b wr %b burst %h want 1 0 0",
               resp_o, write_o, burst_o);
    end
    vec++;
    if (line_o !== orig) begin
      errs++;
      $display("FAIL wr_line_held: got %h want %h", line_o, orig);
    end
    write_i = 0;
    step();
  endtask

  task automatic test_read_wins();
    logic [255:0] wl;
    wl = {64'h4, 64'h3, 64'h2, 64'hCAFE_0001};
    line_i = wl;
    address_i = 32'h0000_3000;
    read_i = 1; write_i = 1;
    step();
    vec++;
    if (read_o !== 1'b1 || write_o !== 1'b0) begin
      errs++;
      $display("FAIL both_rd_first: rd %b wr %b want 1 0",
               read_o, write_o);
    end
    resp_i = 1;
    for (int k = 0; k < 4; k++) begin
      burst_i = 64'(k + 100);
      step();
    end
    resp_i = 0;
    vec++;
    if (resp_o !== 1'b1) begin
      errs++;
      $display("FAIL both_rd_done: got %b want 1", resp_o);
    end
    read_i = 0;
    step();
    step();
    vec++;
    if (write_o !== 1'b1 || read_o !== 1'b0 ||
        burst_o !== 64'hCAFE_0001) begin
      errs++;
      $display("FAIL both_wr_next: wr %b rd %b burst %h want 1 0 cafe0001",
               write_o, read_o, burst_o);
    end
    resp_i = 1;
    for (int k = 0; k < 4; k++) step();
    resp_i = 0;
    vec++;
    if (resp_o !== 1'b1) begin
      errs++;
      $display("FAIL both_wr_done: got %b want 1", resp_o);
    end
    write_i = 0;
    step();
  endtask

  task automatic test_reset_mid_read();
    logic [255:0] exp;
    address_i = 32'h0000_0040;
    read_i = 1;
    step();
    resp_i = 1;
    burst_i = 64'hAAAA; step();
    burst_i = 64'hBBBB; step();
    resp_i = 0;
    #2 reset_n = 1'b0;
    #1;
    vec++;
    if ({read_o, write_o, resp_o, err_o} !== 4'b0 ||
        address_o !== 32'd0 || line_o !== '0 || burst_o !== '0) begin
      errs++;
      $display("FAIL rst_mid: ctl %b addr %h line %h want 0",
               {read_o, write_o, resp_o, err_o}, address_o, line_o);
    end
    read_i = 0;
    step();
    reset_n = 1'b1;
    step();
    exp = {64'h8888, 64'h7777, 64'h6666, 64'h5555};
    address_i = 32'h0000_0080;
    read_i = 1;
    step();
    resp_i = 1;
    burst_i = 64'h5555; step();
    burst_i = 64'h6666; step();
    burst_i = 64'h7777; step();
    burst_i = 64'h8888; step();
    resp_i = 0;
    vec++;
    if (resp_o !== 1'b1 || line_o !== exp || address_o !== 32'h80) begin
      errs++;
      $display("FAIL rst_reread: resp %b addr %h line %h want 1 80 %h",
               resp_o, address_o, line_o, exp);
    end
    read_i = 0;
    step();
  endtask

  task automatic test_wide();
    logic [127:0] b [4];
    logic [511:0] exp;
    for (int k = 0; k < 4; k++)
      b[k] = {32'(k + 1), 32'hFEED_0000, 32'(k * 3), 32'h1234_5678};
    exp = {b[3], b[2], b[1], b[0]};
    w_address_i = 32'h0000_1234;
    w_read_i = 1;
    step();
    vec++;
    if (w_read_o !== 1'b1 || w_address_o !== 32'h0000_1200) begin
      errs++;
      $display("FAIL wide_req: rd %b addr %h want 1 00001200",
               w_read_o, w_address_o);
    end
    w_resp_i = 1;
    for (int k = 0; k < 4; k++) begin
      w_burst_i = b[k];
      step();
    end
    w_resp_i = 0;
    vec++;
    if (w_resp_o !== 1'b1 || w_line_o !== exp) begin
      errs++;
      $display("FAIL wide_done: resp %b line %h want 1 %h",
               w_resp_o, w_line_o, exp);
    end
    w_read_i = 0;
    step();
  endtask

  task automatic test_timeout();
    address_i = 32'h0000_0300;
    read_i = 1;
    step();
    resp_i = 1; burst_i = 64'h1;
    step();
    resp_i = 0;
    for (int c = 2; c < 10; c++) begin
      vec++;
      if (resp_o !== 1'b0 || read_o !== 1'b1) begin
        errs++;
        $display("FAIL tmo_wait c%0d: resp %b rd %b want 0 1",
                 c, resp_o, read_o);
      end
      step();
    end
`ifdef BURST_LINE_ADAPTOR_TIMEOUT_EN
    vec++;
    if (resp_o !== 1'b1 || err_o !== 1'b1 || read_o !== 1'b0) begin
      errs++;
      $display("FAIL tmo_abort: resp %b err %b rd %b want 1 1 0",
               resp_o, err_o, read_o);
    end
    read_i = 0;
    step();
    vec++;
    if (resp_o !== 1'b0 || err_o !== 1'b0 || read_o !== 1'b0) begin
      errs++;
      $display("FAIL tmo_idle: resp %b err %b rd %b want 0 0 0",
               resp_o, err_o, read_o);
    end
`else
    for (int c = 10; c < 30; c++) begin
      vec++;
      if (resp_o !== 1'b0 || err_o !== 1'b0 || read_o !== 1'b1) begin
        errs++;
        $display("FAIL notmo c%0d: resp %b err %b rd %b want 0 0 1",
                 c, resp_o, err_o, read_o);
      end
      step();
    end
    read_i = 0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
`endif
  endtask

  initial begin
    vec = 0;
    errs = 0;
    test_reset();
    test_read();
    test_write_wait();
    test_read_wins();
    test_reset_mid_read();
    test_wide();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
